// File: rtl/command_mode_regs.sv
// Command, mode, mask, request and terminal-count registers of a DMA controller.
// Optional feature macro CMR_AUTOINIT_EN: end-of-process leaves the mask alone on auto-init channels.
module command_mode_regs #(
  parameter int          NUM_CH    = 4,
  parameter logic [7:0]  CMD_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  CS,
  input  logic                  IOR,
  input  logic                  IOW,
  input  logic [3:0]            address,
  input  logic [7:0]            data_in,
  input  logic                  EOP,
  input  logic [NUM_CH-1:0]     tc_ch,
  output logic [7:0]            out_commandWire,
  output logic [6*NUM_CH-1:0]   mode_out,
  output logic [NUM_CH-1:0]     mask_out,
  output logic [NUM_CH-1:0]     request_out,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic                  command_writed
);

  logic                   wr_strobe, rd_strobe, stat_rd, commit, master_clr;
  logic                   wr_q, stat_q;
  logic                   cw_q, cw_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [NUM_CH-1:0][5:0] mode_q, mode_d;
  logic [NUM_CH-1:0]      mask_q, mask_d;
  logic [NUM_CH-1:0]      req_q, req_d;
  logic [NUM_CH-1:0]      tc_q, tc_d;

  assign wr_strobe  = ~CS & ~IOW & IOR;
  assign rd_strobe  = ~CS & ~IOR & IOW;
  assign stat_rd    = rd_strobe & (address == 4'd8);
  // wr_q remembers the strobe, so a long strobe commits only on its first edge
  assign commit     = wr_strobe & ~wr_q;
  assign master_clr = commit & (address == 4'd13);

  always_comb begin
    cmd_d  = cmd_q;
    mode_d = mode_q;
    mask_d = mask_q;
    req_d  = req_q;
    tc_d   = tc_q;
    cw_d   = commit & (address == 4'd8);
    if (commit) begin
      case (address)
        4'd8:  cmd_d = data_in;
        4'd9:  for (int n = 0; n < NUM_CH; n++) if (int'(data_in[1:0]) == n) req_d[n] = data_in[2];
        4'd10: for (int n = 0; n < NUM_CH; n++) if (int'(data_in[1:0]) == n) mask_d[n] = data_in[2];
        4'd11: for (int n = 0; n < NUM_CH; n++) if (int'(data_in[1:0]) == n) mode_d[n] = data_in[7:2];
        4'd14: mask_d = '0;
        4'd15: mask_d = data_in[NUM_CH-1:0];
        default: ;
      endcase
    end
    // End of process is applied on top of any same-cycle CPU write
    if (!EOP) begin
      if (tc_ch == '0) begin
        req_d = '0;
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (tc_ch[n]) begin
            req_d[n] = 1'b0;
`ifdef CMR_AUTOINIT_EN
            if (!mode_d[n][2]) mask_d[n] = 1'b1;
`else
            mask_d[n] = 1'b1;
`endif
          end
        end
      end
    end
    if (stat_q && !stat_rd) tc_d = '0;
    tc_d = tc_d | tc_ch;
    if (master_clr) begin
      cmd_d  = CMD_RESET;
      mode_d = '0;
      mask_d = '1;
      req_d  = '0;
      tc_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cmd_q  <= CMD_RESET;
      mode_q <= '0;
      mask_q <= '1;
      req_q  <= '0;
      tc_q   <= '0;
      cw_q   <= 1'b0;
      stat_q <= 1'b0;
      wr_q   <= wr_strobe;
    end else begin
      cmd_q  <= cmd_d;
      mode_q <= mode_d;
      mask_q <= mask_d;
      req_q  <= req_d;
      tc_q   <= tc_d;
      cw_q   <= cw_d;
      stat_q <= stat_rd;
      wr_q   <= wr_strobe;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (stat_rd) begin
      for (int n = 0; n < NUM_CH; n++) begin
        data_out[4+n] = req_q[n];
        data_out[n]   = tc_q[n];
      end
    end
  end

  assign data_oe         = rd_strobe;
  assign out_commandWire = cmd_q;
  assign mode_out        = mode_q;
  assign mask_out        = mask_q;
  assign request_out     = req_q;
  assign command_writed  = cw_q;

endmodule

// File: tb/tb_command_mode_regs.sv
// Bench for command_mode_regs: operation-level reference model, read/command-pulse scoreboard.
module tb_command_mode_regs;

  localparam logic [7:0] CMD_RESET = 8'h00;

  typedef struct packed {
    logic [7:0]  data;
    logic [7:0]  cmd;
    logic [23:0] mode;
    logic [3:0]  mask;
    logic [3:0]  req;
    logic        cw;
  } rec_t;

  logic        clk = 1'b0;
  logic        RESET, CS, IOR, IOW, EOP;
  logic [3:0]  address;
  logic [7:0]  data_in;
  logic [3:0]  tc_ch;
  logic [7:0]  out_commandWire, data_out;
  logic [23:0] mode_out;
  logic [3:0]  mask_out, request_out;
  logic        data_oe, command_writed;
  logic [7:0]  cmd2, dout2;
  logic [11:0] mode2;
  logic [1:0]  mask2, req2;
  logic        oe2, cw2;

  int checks   = 0;
  int failures = 0;

  rec_t       exp_q[$];
  logic [7:0] cw_q[$];

  logic [7:0] m_cmd;
  logic [7:0] m_mode [4];
  logic [3:0] m_mask, m_req, m_tc;

  always #5 clk = ~clk;

  command_mode_regs #(.NUM_CH(4), .CMD_RESET(CMD_RESET)) dut (
    .clk(clk), .RESET(RESET), .CS(CS), .IOR(IOR), .IOW(IOW), .address(address),
    .data_in(data_in), .EOP(EOP), .tc_ch(tc_ch), .out_commandWire(out_commandWire),
    .mode_out(mode_out), .mask_out(mask_out), .request_out(request_out),
    .data_out(data_out), .data_oe(data_oe), .command_writed(command_writed)
  );

  command_mode_regs #(.NUM_CH(2), .CMD_RESET(CMD_RESET)) dut2 (
    .clk(clk), .RESET(RESET), .CS(CS), .IOR(IOR), .IOW(IOW), .address(address),
    .data_in(data_in), .EOP(EOP), .tc_ch(tc_ch[1:0]), .out_commandWire(cmd2),
    .mode_out(mode2), .mask_out(mask2), .request_out(req2),
    .data_out(dout2), .data_oe(oe2), .command_writed(cw2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_cmd  = CMD_RESET;
    for (int n = 0; n < 4; n++) m_mode[n] = 8'h00;
    m_mask = 4'hF;
    m_req  = 4'h0;
    m_tc   = 4'h0;
  endfunction

  function automatic void model_edge(input bit wr, input logic [3:0] a, input logic [7:0] d,
                                     input bit eop_act, input logic [3:0] tc, input bit clr);
    int ch;
    ch = int'(d[1:0]);
    if (wr && a == 4'd13) begin
      model_reset();
      return;
    end
    if (wr) begin
      case (a)
        4'd8:  begin m_cmd = d; cw_q.push_back(d); end
        4'd9:  m_req[ch]  = d[2];
        4'd10: m_mask[ch] = d[2];
        4'd11: m_mode[ch] = d & 8'hFC;
        4'd14: m_mask = 4'h0;
        4'd15: m_mask = d[3:0];
        default: ;
      endcase
    end
    if (eop_act) begin
      if (tc == 4'h0) m_req = 4'h0;
      for (int n = 0; n < 4; n++) begin
        if (tc[n]) begin
          m_req[n] = 1'b0;
`ifdef CMR_AUTOINIT_EN
          if (m_mode[n][4] == 1'b0) m_mask[n] = 1'b1;
`else
          m_mask[n] = 1'b1;
`endif
        end
      end
    end
    if (clr) m_tc = 4'h0;
    m_tc = m_tc | tc;
  endfunction

  function automatic rec_t snap(input logic [3:0] a);
    rec_t r;
    r.data = (a == 4'd8) ? {m_req, m_tc} : 8'h00;
    r.cmd  = m_cmd;
    r.mask = m_mask;
    r.req  = m_req;
    r.cw   = 1'b0;
    r.mode = '0;
    for (int n = 0; n < 4; n++) r.mode[6*n +: 6] = m_mode[n][7:2];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    CS = 1'b1; IOR = 1'b1; IOW = 1'b1; EOP = 1'b1; tc_ch = 4'h0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int len,
                          input bit eop_act, input logic [3:0] tc);
    CS = 1'b0; IOR = 1'b1; IOW = 1'b0; address = a; data_in = d;
    EOP = !eop_act; tc_ch = tc;
    model_edge(1'b1, a, d, eop_act, tc, 1'b0);
    tick();
    EOP = 1'b1; tc_ch = 4'h0;
    for (int i = 1; i < len; i++) begin
      data_in = 8'($urandom);
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic do_read(input logic [3:0] a, input int len, input logic [3:0] tc_clr);
    exp_q.push_back(snap(a));
    CS = 1'b0; IOR = 1'b0; IOW = 1'b1; address = a;
    for (int i = 0; i < len; i++) tick();
    drive_idle();
    tc_ch = tc_clr;
    model_edge(1'b0, 4'd0, 8'd0, 1'b0, tc_clr, a == 4'd8);
    tick();
    drive_idle();
  endtask

  task automatic do_event(input bit eop_act, input logic [3:0] tc);
    drive_idle();
    EOP = !eop_act; tc_ch = tc;
    model_edge(1'b0, 4'd0, 8'd0, eop_act, tc, 1'b0);
    tick();
    drive_idle();
  endtask

  task automatic do_ignored(input bit both_low, input int len);
    CS = both_low ? 1'b0 : 1'b1; IOR = both_low ? 1'b0 : 1'b1; IOW = 1'b0;
    address = 4'(8 + $urandom_range(0, 7)); data_in = 8'($urandom);
    for (int i = 0; i < len; i++) tick();
    drive_idle();
    tick();
  endtask

  // Write strobe held across the release of reset, with EOP/TC noise during reset
  task automatic do_reset();
    RESET = 1'b1; CS = 1'b0; IOR = 1'b1; IOW = 1'b0; address = 4'd8; data_in = 8'h55;
    EOP = 1'b0; tc_ch = 4'b0001 << $urandom_range(0, 3);
    tick();
    tick();
    model_reset();
    RESET = 1'b0; EOP = 1'b1; tc_ch = 4'h0;
    tick();
    drive_idle();
    tick();
  endtask

  function automatic logic [3:0] rand_tc();
    if ($urandom_range(0, 2) == 0) return 4'b0001 << $urandom_range(0, 3);
    return 4'h0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic oe_prev = 1'b0;
  logic cw_prev = 1'b0;

  always @(negedge clk) begin
    rec_t r;
    if (data_oe === 1'b1 && !oe_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'(data_oe), 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("rd_data", 32'(data_out), 32'(r.data));
        check("rd_cmd", 32'(out_commandWire), 32'(r.cmd));
        check("rd_mode", 32'(mode_out), 32'(r.mode));
        check("rd_mask", 32'(mask_out), 32'(r.mask));
        check("rd_req", 32'(request_out), 32'(r.req));
        check("rd_cw", 32'(command_writed), 32'(r.cw));
      end
    end
    oe_prev = (data_oe === 1'b1);
    if (command_writed === 1'b1) begin
      if (cw_prev) check("cw_width", 32'(cw_prev), 32'd0);
      else if (cw_q.size() == 0) check("unexpected_cw", 32'(command_writed), 32'd0);
      else check("cw_cmd", 32'(out_commandWire), 32'(cw_q.pop_front()));
    end
    cw_prev = (command_writed === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [3:0] wr_addrs [10];
  int sel;
  logic [3:0] a;

  initial begin
    wr_addrs = '{4'd8, 4'd9, 4'd9, 4'd10, 4'd10, 4'd11, 4'd11, 4'd14, 4'd15, 4'd13};
    drive_idle();
    RESET = 1'b1; address = 4'd0; data_in = 8'h00;
    tick();
    tick();
    RESET = 1'b0;
    model_reset();
    tick();

    // reset state
    do_read(4'd8, 1, 4'h0);
    check("reset_cmd", 32'(out_commandWire), 32'h00);
    check("reset_mask", 32'(mask_out), 32'hF);
    check("reset_req", 32'(request_out), 32'h0);
    check("reset_cw", 32'(command_writed), 32'h0);

    // command write held 3 cycles
    do_write(4'd8, 8'hC4, 3, 1'b0, 4'h0);
    check("cmd_c4", 32'(out_commandWire), 32'hC4);
    do_read(4'd8, 2, 4'h0);

    // auto-init channel, masks cleared, EOP on channel 1
    do_write(4'd11, 8'h11, 1, 1'b0, 4'h0);
    do_write(4'd14, 8'h00, 1, 1'b0, 4'h0);
    do_event(1'b1, 4'b0010);
`ifdef CMR_AUTOINIT_EN
    check("eop_autoinit_mask", 32'(mask_out), 32'h0);
`else
    check("eop_autoinit_mask", 32'(mask_out), 32'h2);
`endif
    do_read(4'd8, 1, 4'h0);

    // TC set/clear around status reads
    do_event(1'b0, 4'b0100);
    do_read(4'd8, 2, 4'h0);
    do_read(4'd8, 1, 4'b0001);
    do_read(4'd8, 1, 4'h0);
    do_read(4'd8, 1, 4'h0);
    do_read(4'd3, 1, 4'h0);

    // software request then EOP with no channel
    do_write(4'd9, 8'h06, 1, 1'b0, 4'h0);
    check("req_set_ch2", 32'(request_out), 32'h4);
    do_read(4'd8, 1, 4'h0);
    do_event(1'b1, 4'h0);
    check("req_eop_clear", 32'(request_out), 32'h0);

    // out-of-range channels on the two-channel instance
    do_write(4'd14, 8'h00, 1, 1'b0, 4'h0);
    check("n2_mask_clear", 32'(mask2), 32'h0);
    do_write(4'd10, 8'h07, 1, 1'b0, 4'h0);
    check("n2_mask_oor", 32'(mask2), 32'h0);
    do_write(4'd9, 8'h07, 1, 1'b0, 4'h0);
    check("n2_req_oor", 32'(req2), 32'h0);
    do_write(4'd11, 8'hFF, 1, 1'b0, 4'h0);
    check("n2_mode_oor", 32'(mode2), 32'h100);
    do_read(4'd8, 1, 4'h0);

    // reset with a write strobe spanning its release
    do_reset();
    check("reset_span_cmd", 32'(out_commandWire), 32'h00);
    do_read(4'd8, 1, 4'h0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45) begin
        a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7)) : wr_addrs[$urandom_range(0, 9)];
        do_write(a, 8'($urandom), $urandom_range(1, 3), $urandom_range(0, 3) == 0, rand_tc());
      end else if (sel < 75) begin
        a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd8;
        do_read(a, $urandom_range(1, 3), rand_tc());
      end else if (sel < 90) begin
        do_event($urandom_range(0, 1) == 1, rand_tc());
      end else if (sel < 97) begin
        do_ignored($urandom_range(0, 1) == 1, $urandom_range(1, 2));
      end else begin
        do_reset();
      end
    end

    do_read(4'd8, 1, 4'h0);
    drive_idle();
    for (int i = 0; i < 4; i++) tick();
    check("read_queue_drained", 32'(exp_q.size()), 32'd0);
    check("cw_queue_drained", 32'(cw_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
